solver_pass_sequencer: RTL and testbench
========================================

Name: solver_pass_sequencer

Overview:
- Controller that drives the line solver through repeated passes over the option FIFO.
- Each pass, it pops every line's header word and option words and presents them to the solver one per cycle.
- Options the solver keeps (put_back) are re-pushed to the FIFO; per-line option counts are rebuilt for the next pass.
- Sits between the option FIFO and the solver. It decides solved, unsolvable (contradiction), or ambiguous (no progress) and reports the result to top-level control.

Parameters:
- MAX_LINES, 22, maximum rows+cols; sizes the count arrays.
- OPT_W, 16, width of FIFO and option words.
- CNT_W, 7, width of per-line and total option counts.
- MAX_PASSES, 64, pass limit before the result is declared ambiguous.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse that begins a solve; ignored while busy
- num_rows  in  4  board rows, 1..11
- num_cols  in  4  board cols, 1..11
- init_opt_amnt  in  [MAX_LINES-1:0][CNT_W-1:0]  initial per-line option counts; rows first, then cols
- fifo_rd_data  in  OPT_W  FIFO head word
- fifo_empty  in  1  FIFO empty
- fifo_full  in  1  FIFO full
- fifo_rd_en  out  1  pop FIFO head
- fifo_wr_en  out  1  push fifo_wr_data
- fifo_wr_data  out  OPT_W  word re-pushed to the FIFO
- slv_started  out  1  solver pass-start strobe
- slv_valid  out  1  slv_option is valid this cycle
- slv_option  out  OPT_W  header or option word to the solver
- slv_old_options_amnt  out  [MAX_LINES-1:0][CNT_W-1:0]  per-line counts for the current pass
- slv_all_options_remaining  out  CNT_W  sum of the current-pass counts
- slv_put_back  in  1  solver keeps the option presented in the previous cycle
- slv_solved  in  1  solver reports board fully known
- slv_unsolvable  in  1  solver reports a contradiction
- busy  out  1  solve in progress
- done  out  1  one-cycle pulse when a result is final
- result  out  2  00 none, 01 solved, 10 unsolvable, 11 ambiguous
- pass_count  out  8  number of completed passes

Behaviour:
- Reset: all outputs 0; FSM enters IDLE; count arrays cleared. FIFO contents are not flushed (FIFO owner's responsibility). Reset mid-solve aborts immediately, with no done pulse.
- FSM states: IDLE, LOAD, HDR, OPT, DRAIN, PASS_END, FIN.
- IDLE: on start, latch init_opt_amnt into old_cnt and zero new_cnt; busy=1; go to LOAD.
- LOAD (1 cycle):
  - slv_started=1; slv_all_options_remaining = sum of old_cnt[0..L-1], where L=num_rows+num_cols; sum saturates at 2^CNT_W-1.
  - line=0; go to HDR.
- Pop rule: pop only when !fifo_empty. fifo_rd_en and slv_valid are asserted in the same cycle, and slv_option = fifo_rd_data. While the FIFO is empty, hold state with slv_valid=0.
- HDR:
  - Pop the header; re-push it in the next cycle, unconditionally.
  - opt_left = old_cnt[line]; go to OPT. If opt_left==0, instead set result=10 and go to FIN.
- OPT:
  - Pop one option per cycle and hold it in a 1-deep register.
  - The following cycle, if slv_put_back=1: push the held word and increment new_cnt[line].
  - After the last option of a line: line++. If line==L, go to DRAIN; otherwise go to HDR.
- Pipelining: the put_back push for option k coincides with the pop of word k+1. Occupancy therefore never grows.
  - fifo_full=1 on a required push is a protocol error: result=10, go to FIN.
- DRAIN: one cycle to absorb the final put_back, then go to PASS_END.
- PASS_END, evaluated in priority order:
  1. slv_unsolvable=1 or any new_cnt[i]==0 (i<L): result=10.
  2. slv_solved=1: result=01.
  3. Sum of new_cnt equals the sum of old_cnt (no option discarded): result=11.
  4. pass_count+1==MAX_PASSES: result=11.
  5. Otherwise: old_cnt<=new_cnt, new_cnt<=0, pass_count++, go to LOAD.
- slv_unsolvable sampled high in any HDR/OPT cycle: result=10, go to FIN at the end of that cycle.
- FIN: done=1 for 1 cycle; busy=0; go to IDLE. result and pass_count hold until the next start.
- slv_old_options_amnt = old_cnt at all times.

Optional Feature:
- Macro SOLVER_SEQ_STATS_EN.
- Defined: adds output discarded_total (16 bits), incremented once per option whose put_back was 0; cleared on start and on rst; saturates at 0xFFFF.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- 3x3 board; counts {1,1,1,1,1,1}; solver puts back every option and asserts slv_solved at pass 1 -> done after pass 1, result=01, pass_count=0, FIFO re-holds 12 words.
- Counts {3,3,1,1,3,3}; solver puts back all 14 options in pass 1 -> result=11 at PASS_END of pass 1, with slv_all_options_remaining=14.
- Same counts; pass 1 discards 1 option in col 2 and 1 in col 3 (sum 14->12); pass 2 discards none -> result=11, pass_count=1, second-pass slv_old_options_amnt = {3,3,1,1,2,2}.
- Line 0 has all 3 options discarded -> new_cnt[0]=0 -> result=10 at PASS_END.
- fifo_empty held for 5 cycles mid-line -> no pop and slv_valid=0 during the gap; counts are unchanged afterward.
- rst asserted during OPT -> next cycle busy=0, result=00, all outputs 0, no done pulse.
- With SOLVER_SEQ_STATS_EN defined, the col-discard case -> discarded_total=2.

Source files
------------

// File: rtl/solver_pass_sequencer.sv
// solver_pass_sequencer: runs the line solver over the option FIFO in
// repeated passes. Each pass pops every line header and its options, shows
// them to the solver one per cycle, and re-pushes the header and every option
// the solver keeps. The per-line counts are rebuilt for the next pass. After
// each pass the block decides solved / unsolvable / ambiguous or starts again.
//
// Optional build macro SOLVER_SEQ_STATS_EN adds output discarded_total, a
// saturating count of options the solver dropped during the current solve.
//
// Handshake: a FIFO word transfers on any cycle with fifo_rd_en=1, which is
// only raised while fifo_empty=0. slv_valid is asserted in exactly the same
// cycle and slv_option carries that word. The solver answers for an option
// with slv_put_back in the very next cycle; a kept word is pushed in that
// cycle (fifo_wr_en=1), which must find fifo_full=0.
module solver_pass_sequencer #(
  parameter int MAX_LINES  = 22,
  parameter int OPT_W      = 16,
  parameter int CNT_W      = 7,
  parameter int MAX_PASSES = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [3:0]                      num_rows,
  input  logic [3:0]                      num_cols,
  input  logic [MAX_LINES-1:0][CNT_W-1:0] init_opt_amnt,
  input  logic [OPT_W-1:0]                fifo_rd_data,
  input  logic                            fifo_empty,
  input  logic                            fifo_full,
  output logic                            fifo_rd_en,
  output logic                            fifo_wr_en,
  output logic [OPT_W-1:0]                fifo_wr_data,
  output logic                            slv_started,
  output logic                            slv_valid,
  output logic [OPT_W-1:0]                slv_option,
  output logic [MAX_LINES-1:0][CNT_W-1:0] slv_old_options_amnt,
  output logic [CNT_W-1:0]                slv_all_options_remaining,
  input  logic                            slv_put_back,
  input  logic                            slv_solved,
  input  logic                            slv_unsolvable,
  output logic                            busy,
  output logic                            done,
  output logic [1:0]                      result,
  output logic [7:0]                      pass_count,
  output logic [2:0]                      o_dbg_state
`ifdef SOLVER_SEQ_STATS_EN
  , output logic [15:0]                   discarded_total
`endif
);

  localparam int LINE_W = $clog2(MAX_LINES + 1);
  localparam int SUM_W  = CNT_W + LINE_W;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_LOAD     = 3'd1;
  localparam logic [2:0] S_HDR      = 3'd2;
  localparam logic [2:0] S_OPT      = 3'd3;
  localparam logic [2:0] S_DRAIN    = 3'd4;
  localparam logic [2:0] S_PASS_END = 3'd5;
  localparam logic [2:0] S_FIN      = 3'd6;

  localparam logic [1:0] RES_SOLVED    = 2'b01;
  localparam logic [1:0] RES_UNSOLV    = 2'b10;
  localparam logic [1:0] RES_AMBIGUOUS = 2'b11;

  logic [2:0]                      r_state;
  logic [MAX_LINES-1:0][CNT_W-1:0] r_old_cnt;
  logic [MAX_LINES-1:0][CNT_W-1:0] r_new_cnt;
  logic [LINE_W-1:0]               r_num_lines;
  logic [LINE_W-1:0]               r_line;
  logic [CNT_W-1:0]                r_opt_left;
  logic                            r_hdr_pend;   // header popped last cycle
  logic                            r_opt_pend;   // option popped last cycle
  logic [LINE_W-1:0]               r_opt_line;   // line that option belongs to
  logic [OPT_W-1:0]                r_wb_data;    // word awaiting re-push
  logic [CNT_W-1:0]                r_all_rem;
  logic [1:0]                      r_result;
  logic [7:0]                      r_pass_cnt;

  logic [LINE_W-1:0] w_lines;
  logic [SUM_W-1:0]  w_old_sum;
  logic [SUM_W-1:0]  w_new_sum;
  logic [CNT_W-1:0]  w_old_sum_sat;
  logic              w_any_zero;
  logic              w_push_req;
  logic              w_push_err;
  logic              w_in_pass;
  logic              w_abort;
  logic              w_pop;
  logic              w_last_pass;

  assign w_lines = LINE_W'({1'b0, num_rows} + {1'b0, num_cols});

  // Sums over the active lines and detection of an emptied line
  always_comb begin
    w_old_sum  = '0;
    w_new_sum  = '0;
    w_any_zero = 1'b0;
    for (int i = 0; i < MAX_LINES; i++) begin
      if (i < int'(r_num_lines)) begin
        w_old_sum = w_old_sum + SUM_W'(r_old_cnt[i]);
        w_new_sum = w_new_sum + SUM_W'(r_new_cnt[i]);
        if (r_new_cnt[i] == '0) w_any_zero = 1'b1;
      end
    end
  end

  assign w_old_sum_sat = (w_old_sum > SUM_W'({CNT_W{1'b1}})) ? {CNT_W{1'b1}}
                                                             : w_old_sum[CNT_W-1:0];

  // A push is owed for the header popped last cycle, or for a kept option
  assign w_push_req  = r_hdr_pend | (r_opt_pend & slv_put_back);
  assign w_push_err  = w_push_req & fifo_full;
  assign w_in_pass   = (r_state == S_HDR) | (r_state == S_OPT);
  assign w_abort     = w_in_pass & (slv_unsolvable | w_push_err);
  assign w_pop       = w_in_pass & ~fifo_empty & ~w_abort;
  assign w_last_pass = ((r_pass_cnt + 8'd1) == 8'(MAX_PASSES));

  assign fifo_rd_en   = w_pop;
  assign fifo_wr_en   = w_push_req & ~fifo_full;
  assign fifo_wr_data = r_wb_data;
  assign slv_valid    = w_pop;
  assign slv_option   = w_pop ? fifo_rd_data : '0;
  assign slv_started  = (r_state == S_LOAD);
  assign slv_all_options_remaining = (r_state == S_LOAD) ? w_old_sum_sat : r_all_rem;
  assign slv_old_options_amnt = r_old_cnt;
  assign busy        = (r_state != S_IDLE) & (r_state != S_FIN);
  assign done        = (r_state == S_FIN);
  assign result      = r_result;
  assign pass_count  = r_pass_cnt;
  assign o_dbg_state = r_state;

  // Pass sequencing FSM, write-back pipeline and count bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_old_cnt   <= '0;
      r_new_cnt   <= '0;
      r_num_lines <= '0;
      r_line      <= '0;
      r_opt_left  <= '0;
      r_hdr_pend  <= 1'b0;
      r_opt_pend  <= 1'b0;
      r_opt_line  <= '0;
      r_wb_data   <= '0;
      r_all_rem   <= '0;
      r_result    <= '0;
      r_pass_cnt  <= '0;
    end else begin
      r_hdr_pend <= 1'b0;
      r_opt_pend <= 1'b0;
      // Kept option from last cycle is counted for the next pass
      if (r_opt_pend && slv_put_back && !fifo_full &&
          r_new_cnt[r_opt_line] != {CNT_W{1'b1}})
        r_new_cnt[r_opt_line] <= r_new_cnt[r_opt_line] + CNT_W'(1);

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_old_cnt   <= init_opt_amnt;
            r_new_cnt   <= '0;
            r_num_lines <= w_lines;
            r_result    <= '0;
            r_pass_cnt  <= '0;
            r_state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_all_rem <= w_old_sum_sat;
          r_line    <= '0;
          r_state   <= S_HDR;
        end
        S_HDR: begin
          if (w_abort) begin
            r_result <= RES_UNSOLV;
            r_state  <= S_FIN;
          end else if (w_pop) begin
            r_hdr_pend <= 1'b1;
            r_wb_data  <= fifo_rd_data;
            if (r_old_cnt[r_line] == '0) begin
              r_result <= RES_UNSOLV;
              r_state  <= S_FIN;
            end else begin
              r_opt_left <= r_old_cnt[r_line];
              r_state    <= S_OPT;
            end
          end
        end
        S_OPT: begin
          if (w_abort) begin
            r_result <= RES_UNSOLV;
            r_state  <= S_FIN;
          end else if (w_pop) begin
            r_opt_pend <= 1'b1;
            r_opt_line <= r_line;
            r_wb_data  <= fifo_rd_data;
            r_opt_left <= r_opt_left - CNT_W'(1);
            if (r_opt_left == CNT_W'(1)) begin
              r_line <= r_line + LINE_W'(1);
              if ((r_line + LINE_W'(1)) == r_num_lines) r_state <= S_DRAIN;
              else                                      r_state <= S_HDR;
            end
          end
        end
        S_DRAIN: begin
          if (w_push_err) begin
            r_result <= RES_UNSOLV;
            r_state  <= S_FIN;
          end else begin
            r_state <= S_PASS_END;
          end
        end
        S_PASS_END: begin
          if (slv_unsolvable || w_any_zero) begin
            r_result <= RES_UNSOLV;
            r_state  <= S_FIN;
          end else if (slv_solved) begin
            r_result <= RES_SOLVED;
            r_state  <= S_FIN;
          end else if (w_new_sum == w_old_sum || w_last_pass) begin
            r_result <= RES_AMBIGUOUS;
            r_state  <= S_FIN;
          end else begin
            r_old_cnt  <= r_new_cnt;
            r_new_cnt  <= '0;
            r_pass_cnt <= r_pass_cnt + 8'd1;
            r_state    <= S_LOAD;
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef SOLVER_SEQ_STATS_EN
  logic [15:0] r_disc;

  // Saturating tally of options the solver dropped in this solve
  always_ff @(posedge clk) begin
    if (rst) begin
      r_disc <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_disc <= '0;
    end else if (r_opt_pend && !slv_put_back && r_disc != 16'hFFFF) begin
      r_disc <= r_disc + 16'd1;
    end
  end

  assign discarded_total = r_disc;
`endif

endmodule

// File: tb/tb_solver_pass_sequencer.sv
// Directed bench for solver_pass_sequencer on a 3x3 board: a word-level FIFO
// model, a registered solver model driven by per-pass discard masks, and one
// task per scenario with hand-computed expectations.
module tb_solver_pass_sequencer;
  localparam int ML = 22;
  localparam int CW = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst = 1'b1;
  logic                     start = 1'b0;
  logic [3:0]               num_rows = 4'd3;
  logic [3:0]               num_cols = 4'd3;
  logic [ML-1:0][CW-1:0]    init_amnt = '0;
  logic [15:0]              fifo_rd_data;
  logic                     fifo_empty;
  logic                     fifo_full = 1'b0;
  logic                     fifo_rd_en, fifo_wr_en;
  logic [15:0]              fifo_wr_data;
  logic                     slv_started, slv_valid;
  logic [15:0]              slv_option;
  logic [ML-1:0][CW-1:0]    slv_old_options_amnt;
  logic [CW-1:0]            slv_all_options_remaining;
  logic                     slv_put_back = 1'b0;
  logic                     slv_solved = 1'b0;
  logic                     slv_unsolvable = 1'b0;
  logic                     busy, done;
  logic [1:0]               result;
  logic [7:0]               pass_count;
  logic [2:0]               dbg_state;
`ifdef SOLVER_SEQ_STATS_EN
  logic [15:0]              discarded_total;
`endif

  solver_pass_sequencer dut (
    .clk(clk), .rst(rst), .start(start),
    .num_rows(num_rows), .num_cols(num_cols), .init_opt_amnt(init_amnt),
    .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .fifo_rd_en(fifo_rd_en), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .slv_started(slv_started), .slv_valid(slv_valid), .slv_option(slv_option),
    .slv_old_options_amnt(slv_old_options_amnt),
    .slv_all_options_remaining(slv_all_options_remaining),
    .slv_put_back(slv_put_back), .slv_solved(slv_solved),
    .slv_unsolvable(slv_unsolvable),
    .busy(busy), .done(done), .result(result), .pass_count(pass_count),
    .o_dbg_state(dbg_state)
`ifdef SOLVER_SEQ_STATS_EN
    , .discarded_total(discarded_total)
`endif
  );

  int total = 0;
  int bad = 0;

  // FIFO model: words encoded as header {A,0,line} and option {B,idx,line}
  logic [15:0] fmem [0:63];
  logic [6:0]  f_rd = '0;
  logic [6:0]  f_wr = '0;
  logic [6:0]  f_occ;
  logic        fifo_gap = 1'b0;
  logic        tb_push = 1'b0;
  logic        tb_flush = 1'b0;
  logic [15:0] tb_word = '0;

  assign f_occ        = f_wr - f_rd;
  assign fifo_empty   = (f_occ == 7'd0) || fifo_gap;
  assign fifo_rd_data = fmem[f_rd[5:0]];

  always @(posedge clk) begin
    if (tb_flush) begin
      f_rd <= f_wr;
    end else begin
      if (fifo_rd_en) f_rd <= f_rd + 7'd1;
      if (fifo_wr_en) begin
        fmem[f_wr[5:0]] <= fifo_wr_data;
        f_wr <= f_wr + 7'd1;
      end else if (tb_push) begin
        fmem[f_wr[5:0]] <= tb_word;
        f_wr <= f_wr + 7'd1;
      end
    end
  end

  // Solver model: answers one cycle after each option with a registered put_back
  logic [15:0] mask1 [0:31];
  logic [15:0] mask2 [0:31];
  logic [7:0]  pass_num = '0;

  always @(posedge clk) begin
    if (start) pass_num <= '0;
    else if (slv_started) pass_num <= pass_num + 8'd1;
    if (slv_valid && slv_option[15:12] == 4'hB) begin
      if (pass_num == 8'd1) slv_put_back <= !mask1[slv_option[4:0]][slv_option[11:8]];
      else                  slv_put_back <= !mask2[slv_option[4:0]][slv_option[11:8]];
    end else begin
      slv_put_back <= 1'b0;
    end
  end

  // Values captured while waiting for done
  logic [CW-1:0]         cap_rem [0:3];
  logic [ML-1:0][CW-1:0] cap_amnt [0:3];
  int                    n_starts = 0;
  logic [1:0]            got_res = '0;
  logic [7:0]            got_pc = '0;
  bit                    got_to = 0;

  task automatic cfg6(input int a0, input int a1, input int a2,
                      input int a3, input int a4, input int a5);
    num_rows = 4'd3;
    num_cols = 4'd3;
    init_amnt = '0;
    init_amnt[0] = CW'(a0); init_amnt[1] = CW'(a1); init_amnt[2] = CW'(a2);
    init_amnt[3] = CW'(a3); init_amnt[4] = CW'(a4); init_amnt[5] = CW'(a5);
    for (int i = 0; i < 32; i++) begin
      mask1[i] = '0;
      mask2[i] = '0;
    end
  endtask

  task automatic load_fifo();
    @(negedge clk) tb_flush = 1'b1;
    @(negedge clk) tb_flush = 1'b0;
    for (int l = 0; l < 6; l++) begin
      @(negedge clk);
      tb_push = 1'b1;
      tb_word = {4'hA, 4'h0, 8'(l)};
      for (int i = 0; i < int'(init_amnt[l]); i++) begin
        @(negedge clk);
        tb_word = {4'hB, 4'(i), 8'(l)};
      end
    end
    @(negedge clk) tb_push = 1'b0;
  endtask

  task automatic pulse_start();
    n_starts = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit got;
    got = 0;
    got_to = 0;
    for (int c = 0; c < budget && !got; c++) begin
      if (slv_started && n_starts < 4) begin
        cap_rem[n_starts]  = slv_all_options_remaining;
        cap_amnt[n_starts] = slv_old_options_amnt;
        n_starts++;
      end
      if (done) begin
        got = 1;
        got_res = result;
        got_pc = pass_count;
      end else begin
        @(negedge clk);
      end
    end
    if (!got) got_to = 1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++;
      $display("FAIL reset_busy_done got busy=%b done=%b want 0 0", busy, done); end
    total++; if (result !== 2'b00 || pass_count !== 8'd0) begin bad++;
      $display("FAIL reset_result got result=%b pass=%0d want 00 0", result, pass_count); end
    total++; if (fifo_rd_en !== 1'b0 || fifo_wr_en !== 1'b0 || slv_valid !== 1'b0 || slv_started !== 1'b0) begin bad++;
      $display("FAIL reset_strobes got rd=%b wr=%b vld=%b st=%b want 0", fifo_rd_en, fifo_wr_en, slv_valid, slv_started); end
    total++; if (slv_old_options_amnt !== '0 || slv_all_options_remaining !== '0) begin bad++;
      $display("FAIL reset_counts got amnt=%h rem=%0d want 0", slv_old_options_amnt, slv_all_options_remaining); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_solved_first_pass();
    logic [15:0] exp_q[$];
    cfg6(1, 1, 1, 1, 1, 1);
    slv_solved = 1'b1;
    load_fifo();
    pulse_start();
    total++; if (busy !== 1'b1) begin bad++;
      $display("FAIL solved_busy got %b want 1", busy); end
    wait_done(500);
    slv_solved = 1'b0;
    total++; if (got_to) begin bad++; $display("FAIL solved_timeout got no done want done"); end
    total++; if (got_res !== 2'b01 || got_pc !== 8'd0) begin bad++;
      $display("FAIL solved_result got res=%b pass=%0d want 01 0", got_res, got_pc); end
    total++; if (n_starts != 1 || cap_rem[0] !== 7'd6) begin bad++;
      $display("FAIL solved_remaining got starts=%0d rem=%0d want 1 6", n_starts, cap_rem[0]); end
    total++; if (f_occ !== 7'd12) begin bad++;
      $display("FAIL solved_occupancy got %0d want 12", f_occ); end
    for (int l = 0; l < 6; l++) begin
      exp_q.push_back({4'hA, 4'h0, 8'(l)});
      exp_q.push_back({4'hB, 4'h0, 8'(l)});
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      logic [6:0] idx;
      idx = f_rd + 7'(i);
      total++; if (fmem[idx[5:0]] !== exp_q[i]) begin bad++;
        $display("FAIL solved_fifo_word%0d got %h want %h", i, fmem[idx[5:0]], exp_q[i]); end
    end
  endtask

  task automatic test_ambiguous_no_discard();
    cfg6(3, 3, 1, 1, 3, 3);
    load_fifo();
    pulse_start();
    wait_done(500);
    total++; if (got_to) begin bad++; $display("FAIL ambig_timeout got no done want done"); end
    total++; if (got_res !== 2'b11 || got_pc !== 8'd0) begin bad++;
      $display("FAIL ambig_result got res=%b pass=%0d want 11 0", got_res, got_pc); end
    total++; if (cap_rem[0] !== 7'd14) begin bad++;
      $display("FAIL ambig_remaining got %0d want 14", cap_rem[0]); end
    total++; if (f_occ !== 7'd20) begin bad++;
      $display("FAIL ambig_occupancy got %0d want 20", f_occ); end
  endtask

  task automatic test_two_pass_discard();
    logic [ML-1:0][CW-1:0] exp_amnt;
    cfg6(3, 3, 1, 1, 3, 3);
    mask1[4] = 16'h0001;
    mask1[5] = 16'h0001;
    exp_amnt = '0;
    exp_amnt[0] = 7'd3; exp_amnt[1] = 7'd3; exp_amnt[2] = 7'd1;
    exp_amnt[3] = 7'd1; exp_amnt[4] = 7'd2; exp_amnt[5] = 7'd2;
    load_fifo();
    pulse_start();
    wait_done(1000);
    total++; if (got_to) begin bad++; $display("FAIL two_pass_timeout got no done want done"); end
    total++; if (got_res !== 2'b11 || got_pc !== 8'd1) begin bad++;
      $display("FAIL two_pass_result got res=%b pass=%0d want 11 1", got_res, got_pc); end
    total++; if (n_starts != 2 || cap_rem[0] !== 7'd14 || cap_rem[1] !== 7'd12) begin bad++;
      $display("FAIL two_pass_remaining got starts=%0d rem0=%0d rem1=%0d want 2 14 12", n_starts, cap_rem[0], cap_rem[1]); end
    total++; if (cap_amnt[1] !== exp_amnt) begin bad++;
      $display("FAIL two_pass_amnt got %h want %h", cap_amnt[1], exp_amnt); end
    total++; if (f_occ !== 7'd18) begin bad++;
      $display("FAIL two_pass_occupancy got %0d want 18", f_occ); end
`ifdef SOLVER_SEQ_STATS_EN
    total++; if (discarded_total !== 16'd2) begin bad++;
      $display("FAIL two_pass_discarded got %0d want 2", discarded_total); end
`endif
  endtask

  task automatic test_rst_after_result();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    total++; if (result !== 2'b00 || pass_count !== 8'd0) begin bad++;
      $display("FAIL rst_after_result got res=%b pass=%0d want 00 0", result, pass_count); end
    total++; if (slv_old_options_amnt !== '0 || slv_all_options_remaining !== '0) begin bad++;
      $display("FAIL rst_after_counts got amnt=%h rem=%0d want 0", slv_old_options_amnt, slv_all_options_remaining); end
  endtask

  task automatic test_line_emptied();
    cfg6(3, 3, 1, 1, 3, 3);
    mask1[0] = 16'h0007;
    load_fifo();
    pulse_start();
    wait_done(500);
    total++; if (got_to) begin bad++; $display("FAIL emptied_timeout got no done want done"); end
    total++; if (got_res !== 2'b10 || got_pc !== 8'd0) begin bad++;
      $display("FAIL emptied_result got res=%b pass=%0d want 10 0", got_res, got_pc); end
    total++; if (f_occ !== 7'd17) begin bad++;
      $display("FAIL emptied_occupancy got %0d want 17", f_occ); end
  endtask

  task automatic test_fifo_gap();
    bit found;
    cfg6(3, 3, 1, 1, 3, 3);
    load_fifo();
    pulse_start();
    found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      if (slv_valid && slv_option == 16'hB000) found = 1;
      else @(negedge clk);
    end
    total++; if (!found) begin bad++; $display("FAIL gap_find got no option0 want option0"); end
    for (int g = 0; g < 5; g++) begin
      @(negedge clk);
      fifo_gap = 1'b1;
      #1;
      total++; if (slv_valid !== 1'b0 || fifo_rd_en !== 1'b0) begin bad++;
        $display("FAIL gap_cycle%0d got vld=%b rd=%b want 0 0", g, slv_valid, fifo_rd_en); end
    end
    @(negedge clk) fifo_gap = 1'b0;
    wait_done(500);
    total++; if (got_to) begin bad++; $display("FAIL gap_timeout got no done want done"); end
    total++; if (got_res !== 2'b11 || got_pc !== 8'd0) begin bad++;
      $display("FAIL gap_result got res=%b pass=%0d want 11 0", got_res, got_pc); end
    total++; if (slv_old_options_amnt !== init_amnt || f_occ !== 7'd20) begin bad++;
      $display("FAIL gap_counts got amnt=%h occ=%0d want %h 20", slv_old_options_amnt, f_occ, init_amnt); end
  endtask

  task automatic test_unsolvable_mid_pass();
    bit found;
    cfg6(1, 1, 1, 1, 1, 1);
    load_fifo();
    pulse_start();
    found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      if (slv_valid) found = 1;
      else @(negedge clk);
    end
    slv_unsolvable = 1'b1;
    wait_done(100);
    slv_unsolvable = 1'b0;
    total++; if (got_to || !found) begin bad++; $display("FAIL unsolv_timeout got no done want done"); end
    total++; if (got_res !== 2'b10 || got_pc !== 8'd0) begin bad++;
      $display("FAIL unsolv_result got res=%b pass=%0d want 10 0", got_res, got_pc); end
  endtask

  task automatic test_fifo_full_error();
    cfg6(1, 1, 1, 1, 1, 1);
    load_fifo();
    fifo_full = 1'b1;
    pulse_start();
    wait_done(100);
    fifo_full = 1'b0;
    total++; if (got_to) begin bad++; $display("FAIL full_timeout got no done want done"); end
    total++; if (got_res !== 2'b10) begin bad++;
      $display("FAIL full_result got res=%b want 10", got_res); end
  endtask

  task automatic test_rst_mid_opt();
    bit found;
    bit saw_done;
    cfg6(3, 3, 1, 1, 3, 3);
    load_fifo();
    pulse_start();
    found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      if (dbg_state == 3'd3) found = 1;
      else @(negedge clk);
    end
    total++; if (!found || busy !== 1'b1) begin bad++;
      $display("FAIL rst_mid_reach got found=%0d busy=%b want 1 1", found, busy); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0 || result !== 2'b00) begin bad++;
      $display("FAIL rst_mid_state got busy=%b done=%b res=%b want 0 0 00", busy, done, result); end
    total++; if (slv_valid !== 1'b0 || fifo_wr_en !== 1'b0 || fifo_rd_en !== 1'b0 || slv_old_options_amnt !== '0) begin bad++;
      $display("FAIL rst_mid_outputs got vld=%b wr=%b rd=%b amnt=%h want 0", slv_valid, fifo_wr_en, fifo_rd_en, slv_old_options_amnt); end
    rst = 1'b0;
    saw_done = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    total++; if (saw_done) begin bad++; $display("FAIL rst_mid_no_done got done=1 want 0"); end
  endtask

  initial begin
    test_reset();
    test_solved_first_pass();
    test_ambiguous_no_discard();
    test_two_pass_discard();
    test_rst_after_result();
    test_line_emptied();
    test_fifo_gap();
    test_unsolvable_mid_pass();
    test_fifo_full_error();
    test_rst_mid_opt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
